// File: rtl/lvds_word_align.sv
// rtl/lvds_word_align.sv - per-lane bitslip/polarity word-alignment trainer for a dual-lane deserializer
module lvds_word_align #(
    parameter int          DATA_WIDTH    = 8,
    parameter logic [7:0]  TRAIN_PATTERN = 8'hE8,
    parameter int          SETTLE_CYCLES = 4,
    parameter int          MATCH_COUNT   = 4,
    parameter int          MAX_SLIPS     = 16
) (
    input  logic        clkdiv,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] din,
    output logic        bitslip_1,
    output logic        bitslip_2,
    output logic        reva_flag,
    output logic        revb_flag,
    output logic        locked_a,
    output logic        locked_b,
    output logic        done,
    output logic        fail,
    output logic [4:0]  slip_count_a,
    output logic [4:0]  slip_count_b
);

    localparam int                    OFS         = 16 - 2 * DATA_WIDTH;
    localparam logic [DATA_WIDTH-1:0] PAT         = TRAIN_PATTERN[DATA_WIDTH-1:0];
    localparam logic [DATA_WIDTH-1:0] NPAT        = ~PAT;
    localparam logic [3:0]            SETTLE_LOAD = 4'(SETTLE_CYCLES);
    localparam logic [4:0]            MATCH_LAST  = 5'(MATCH_COUNT);
    localparam logic [4:0]            SLIP_LIMIT  = 5'(MAX_SLIPS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CHECK,
        ST_SLIP,
        ST_LOCKED,
        ST_FAIL
    } state_t;

    // Lane 0 is lane A (odd bits), lane 1 is lane B (even bits).
    logic [DATA_WIDTH-1:0] lane_word [2];

    state_t     state_q   [2];
    state_t     state_d   [2];
    logic [3:0] settle_q  [2];
    logic [3:0] settle_d  [2];
    logic [3:0] match_q   [2];
    logic [3:0] match_d   [2];
    logic [4:0] slips_q   [2];
    logic [4:0] slips_d   [2];
    logic       tried_q   [2];
    logic       tried_d   [2];
    logic       rev_q     [2];
    logic       rev_d     [2];
    logic       bitslip_q [2];
    logic       bitslip_d [2];
    logic       locked_q  [2];
    logic       locked_d  [2];
    logic       done_q;
    logic       done_d;
    logic       fail_q;
    logic       fail_d;

    // Deinterleave the PHY word; valid bits live in the top 2*DATA_WIDTH positions.
    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_extract
        assign lane_word[0][i] = din[OFS + 2 * i + 1];
        assign lane_word[1][i] = din[OFS + 2 * i];
    end

    if (OFS > 0) begin : g_low_bits
        logic unused_low_bits;
        assign unused_low_bits = ^din[OFS-1:0];
    end

    // Next-state logic for both lane trainers plus the combined status flags.
    always_comb begin
        for (int l = 0; l < 2; l++) begin
            state_d[l]   = state_q[l];
            settle_d[l]  = settle_q[l];
            match_d[l]   = match_q[l];
            slips_d[l]   = slips_q[l];
            tried_d[l]   = tried_q[l];
            rev_d[l]     = rev_q[l];
            bitslip_d[l] = 1'b0;
            locked_d[l]  = locked_q[l];

            if (start) begin
                // Restart wins over everything, including a pending slip pulse.
                state_d[l]  = ST_SETTLE;
                settle_d[l] = SETTLE_LOAD;
                match_d[l]  = 4'd0;
                slips_d[l]  = 5'd0;
                tried_d[l]  = 1'b0;
                rev_d[l]    = 1'b0;
                locked_d[l] = 1'b0;
            end else begin
                case (state_q[l])
                    ST_SETTLE: begin
                        // The word present while the counter reads zero is still discarded.
                        if (settle_q[l] == 4'd0) begin
                            state_d[l] = ST_CHECK;
                            match_d[l] = 4'd0;
                        end else begin
                            settle_d[l] = settle_q[l] - 4'd1;
                        end
                    end
                    ST_CHECK: begin
                        if (lane_word[l] == PAT) begin
                            match_d[l] = match_q[l] + 4'd1;
                            if (({1'b0, match_q[l]} + 5'd1) == MATCH_LAST) begin
                                state_d[l]  = ST_LOCKED;
                                locked_d[l] = 1'b1;
                            end
                        end else if (lane_word[l] == NPAT && !tried_q[l]) begin
                            // Inverted pattern: flip polarity once before resorting to slips.
                            rev_d[l]    = ~rev_q[l];
                            tried_d[l]  = 1'b1;
                            state_d[l]  = ST_SETTLE;
                            settle_d[l] = SETTLE_LOAD;
                        end else if (slips_q[l] == SLIP_LIMIT) begin
                            state_d[l] = ST_FAIL;
                        end else begin
                            state_d[l]   = ST_SLIP;
                            bitslip_d[l] = 1'b1;
                        end
                    end
                    ST_SLIP: begin
                        slips_d[l]  = slips_q[l] + 5'd1;
                        tried_d[l]  = 1'b0;
                        state_d[l]  = ST_SETTLE;
                        settle_d[l] = SETTLE_LOAD;
                    end
                    default: begin
                        // IDLE, LOCKED and FAIL hold until start.
                    end
                endcase
            end
        end

        done_d = (state_d[0] == ST_LOCKED || state_d[0] == ST_FAIL) &&
                 (state_d[1] == ST_LOCKED || state_d[1] == ST_FAIL);
        fail_d = (state_d[0] == ST_FAIL) || (state_d[1] == ST_FAIL);
    end

    // State and output registers; reset returns the PHY controls to neutral at once.
    always_ff @(posedge clkdiv or negedge reset) begin
        if (!reset) begin
            for (int l = 0; l < 2; l++) begin
                state_q[l]   <= ST_IDLE;
                settle_q[l]  <= 4'd0;
                match_q[l]   <= 4'd0;
                slips_q[l]   <= 5'd0;
                tried_q[l]   <= 1'b0;
                rev_q[l]     <= 1'b0;
                bitslip_q[l] <= 1'b0;
                locked_q[l]  <= 1'b0;
            end
            done_q <= 1'b0;
            fail_q <= 1'b0;
        end else begin
            for (int l = 0; l < 2; l++) begin
                state_q[l]   <= state_d[l];
                settle_q[l]  <= settle_d[l];
                match_q[l]   <= match_d[l];
                slips_q[l]   <= slips_d[l];
                tried_q[l]   <= tried_d[l];
                rev_q[l]     <= rev_d[l];
                bitslip_q[l] <= bitslip_d[l];
                locked_q[l]  <= locked_d[l];
            end
            done_q <= done_d;
            fail_q <= fail_d;
        end
    end

    assign bitslip_1    = bitslip_q[0];
    assign bitslip_2    = bitslip_q[1];
    assign reva_flag    = rev_q[0];
    assign revb_flag    = rev_q[1];
    assign locked_a     = locked_q[0];
    assign locked_b     = locked_q[1];
    assign done         = done_q;
    assign fail         = fail_q;
    assign slip_count_a = slips_q[0];
    assign slip_count_b = slips_q[1];

endmodule

// File: tb/tb_lvds_word_align.sv
// tb/tb_lvds_word_align.sv - randomized bench for lvds_word_align against a lane/PHY model
module tb_lvds_word_align;

    localparam int         S    = 4;
    localparam int         M    = 4;
    localparam int         MAXS = 16;
    localparam logic [7:0] PAT  = 8'hE8;

    logic        clkdiv = 1'b0;
    logic        reset  = 1'b0;
    logic        start  = 1'b0;
    logic [15:0] din    = 16'h0;
    logic        bitslip_1, bitslip_2, reva_flag, revb_flag;
    logic        locked_a, locked_b, done, fail;
    logic [4:0]  slip_count_a, slip_count_b;

    int n_total = 0;
    int n_bad   = 0;

    // PHY model: lane word is the pattern rotated by the current bit offset,
    // optionally inverted by the physical wiring and by the DUT's rev flag.
    int off_a, off_b;
    bit inv_a, inv_b, zero_a, zero_b;

    lvds_word_align #(
        .DATA_WIDTH    (8),
        .TRAIN_PATTERN (PAT),
        .SETTLE_CYCLES (S),
        .MATCH_COUNT   (M),
        .MAX_SLIPS     (MAXS)
    ) dut (
        .clkdiv       (clkdiv),
        .reset        (reset),
        .start        (start),
        .din          (din),
        .bitslip_1    (bitslip_1),
        .bitslip_2    (bitslip_2),
        .reva_flag    (reva_flag),
        .revb_flag    (revb_flag),
        .locked_a     (locked_a),
        .locked_b     (locked_b),
        .done         (done),
        .fail         (fail),
        .slip_count_a (slip_count_a),
        .slip_count_b (slip_count_b)
    );

    always #5 clkdiv = ~clkdiv;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
        end
    endtask

    function automatic logic [7:0] lane_word(input int off, input bit inv, input bit zero, input logic rev);
        logic [15:0] dbl;
        logic [7:0]  w;
        if (zero) return 8'h00;
        dbl = {PAT, PAT} << off;
        w   = dbl[15:8];
        if (inv ^ rev) w = ~w;
        return w;
    endfunction

    task automatic drive_din();
        logic [7:0] wa, wb;
        wa = lane_word(off_a, inv_a, zero_a, reva_flag);
        wb = lane_word(off_b, inv_b, zero_b, revb_flag);
        for (int i = 0; i < 8; i++) begin
            din[2*i+1] = wa[i];
            din[2*i]   = wb[i];
        end
    endtask

    task automatic tick();
        @(posedge clkdiv);
        #1;
        if (bitslip_1) off_a = (off_a + 1) % 8;
        if (bitslip_2) off_b = (off_b + 1) % 8;
        drive_din();
    endtask

    // Expected terminal edge (counted from the start edge) of one lane.
    function automatic int lane_end(input int s, input bit inv, input bit zero);
        if (zero) return MAXS * (S + 3) + S + 2;
        return s * (S + 3) + (inv ? (S + 2) : 0) + S + 1 + M;
    endfunction

    task automatic run_trial(input string nm, input int sa, input bit ia, input bit za,
                             input int sb, input bit ib, input bit zb);
        int pa, pb, ta, tb, td, last_a, last_b, gap;
        bit consec, prev_a, prev_b;
        int ea, eb;
        off_a = (8 - sa) % 8; inv_a = ia; zero_a = za;
        off_b = (8 - sb) % 8; inv_b = ib; zero_b = zb;
        drive_din();
        start = 1'b1;
        tick();
        start = 1'b0;
        pa = 0; pb = 0; ta = -1; tb = -1; td = -1;
        last_a = -1000; last_b = -1000; gap = 1000;
        consec = 0; prev_a = 0; prev_b = 0;
        for (int t = 1; t <= 400 && td < 0; t++) begin
            tick();
            if (bitslip_1) begin
                pa++;
                if (prev_a) consec = 1;
                if (t - last_a < gap) gap = t - last_a;
                last_a = t;
            end
            if (bitslip_2) begin
                pb++;
                if (prev_b) consec = 1;
                if (t - last_b < gap) gap = t - last_b;
                last_b = t;
            end
            prev_a = bitslip_1;
            prev_b = bitslip_2;
            if (locked_a && ta < 0) ta = t;
            if (locked_b && tb < 0) tb = t;
            if (done && td < 0) td = t;
        end
        ea = lane_end(sa, ia, za);
        eb = lane_end(sb, ib, zb);
        check_eq({nm, ".locked_a"}, locked_a, !za);
        check_eq({nm, ".locked_b"}, locked_b, !zb);
        check_eq({nm, ".slips_a"}, slip_count_a, za ? MAXS : sa);
        check_eq({nm, ".slips_b"}, slip_count_b, zb ? MAXS : sb);
        check_eq({nm, ".pulses_a"}, pa, za ? MAXS : sa);
        check_eq({nm, ".pulses_b"}, pb, zb ? MAXS : sb);
        check_eq({nm, ".reva"}, reva_flag, za ? 1'b0 : ia);
        check_eq({nm, ".revb"}, revb_flag, zb ? 1'b0 : ib);
        check_eq({nm, ".lock_t_a"}, ta, za ? -1 : ea);
        check_eq({nm, ".lock_t_b"}, tb, zb ? -1 : eb);
        check_eq({nm, ".done_t"}, td, (ea > eb) ? ea : eb);
        check_eq({nm, ".fail"}, fail, za | zb);
        check_eq({nm, ".no_back_to_back"}, consec, 0);
        check_eq({nm, ".gap_ok"}, gap >= S + 1, 1);
    endtask

    initial begin
        int t_lock;
        bit reached;
        off_a = 0; off_b = 0; inv_a = 0; inv_b = 0; zero_a = 0; zero_b = 0;
        drive_din();
        repeat (3) tick();
        check_eq("rst.bitslip_1", bitslip_1, 0);
        check_eq("rst.bitslip_2", bitslip_2, 0);
        check_eq("rst.reva", reva_flag, 0);
        check_eq("rst.revb", revb_flag, 0);
        check_eq("rst.locked_a", locked_a, 0);
        check_eq("rst.locked_b", locked_b, 0);
        check_eq("rst.done", done, 0);
        check_eq("rst.fail", fail, 0);
        check_eq("rst.slips_a", slip_count_a, 0);
        check_eq("rst.slips_b", slip_count_b, 0);
        reset = 1'b1;
        repeat (3) tick();
        check_eq("idle.locked_a", locked_a, 0);
        check_eq("idle.done", done, 0);

        run_trial("aligned", 0, 0, 0, 0, 0, 0);
        run_trial("slip3_a", 3, 0, 0, 0, 0, 0);
        run_trial("npat_b", 0, 0, 0, 0, 1, 0);
        run_trial("never_a", 0, 0, 1, 2, 0, 0);

        // Reset in SETTLE right after the second slip of lane A.
        off_a = 3; inv_a = 0; zero_a = 0; off_b = 0; inv_b = 0; zero_b = 0;
        drive_din();
        start = 1'b1;
        tick();
        start = 1'b0;
        reached = 0;
        for (int t = 0; t < 100 && !reached; t++) begin
            tick();
            if (slip_count_a == 5'd2) reached = 1;
        end
        check_eq("rst_mid.reached", reached, 1);
        reset = 1'b0;
        #1;
        check_eq("rst_mid.bitslip_1", bitslip_1, 0);
        check_eq("rst_mid.reva", reva_flag, 0);
        check_eq("rst_mid.slips_a", slip_count_a, 0);
        check_eq("rst_mid.locked_b", locked_b, 0);
        check_eq("rst_mid.done", done, 0);
        repeat (2) tick();
        reset = 1'b1;
        tick();
        run_trial("rst_retrain", 3, 0, 0, 0, 0, 0);

        // Restart from LOCKED with lane B polarity flipped.
        run_trial("locked_rev", 0, 0, 0, 0, 1, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("restart.revb", revb_flag, 0);
        check_eq("restart.locked_b", locked_b, 0);
        check_eq("restart.locked_a", locked_a, 0);
        check_eq("restart.done", done, 0);
        t_lock = -1;
        for (int t = 1; t <= 100 && t_lock < 0; t++) begin
            tick();
            if (locked_b) t_lock = t;
        end
        check_eq("restart.lock_t_b", t_lock, lane_end(0, 1, 0));
        check_eq("restart.revb_final", revb_flag, 1);
        check_eq("restart.locked_a_final", locked_a, 1);

        for (int k = 0; k < 10; k++) begin
            int sa, sb;
            bit ia, ib, za, zb;
            sa = $urandom_range(0, 7);
            sb = $urandom_range(0, 7);
            ia = 1'($urandom_range(0, 1));
            ib = 1'($urandom_range(0, 1));
            za = ($urandom_range(0, 5) == 0);
            zb = ($urandom_range(0, 5) == 0);
            run_trial($sformatf("rand%0d", k), sa, ia, za, sb, ib, zb);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/lvds_word_align.md
Name: lvds_word_align

Overview:
- Per-lane word-alignment trainer that sits directly downstream of the dual-lane ISERDES2 deserializer PHY in the ADC receive path, clocked on its divided clock.
- Takes the PHY's interleaved 16-bit parallel output and, for each lane independently, issues single-cycle bitslip pulses and sets the per-lane polarity-reverse flags until the lane word matches a known training pattern.
- Then reports lock. The bitslip and reverse-flag outputs feed straight back into the PHY.

Parameters:
- DATA_WIDTH, 8, bits per lane word; legal 4..8; must equal the PHY's DATA_WIDTH.
- TRAIN_PATTERN, 8'hE8, expected lane word; only the low DATA_WIDTH bits are used; no rotation of it equals its complement.
- SETTLE_CYCLES, 4, clkdiv cycles waited after any bitslip or polarity change before comparing; covers PHY pipeline latency; legal 1..15.
- MATCH_COUNT, 4, consecutive matching words required to declare lock; legal 1..15.
- MAX_SLIPS, 16, bitslip attempts before a lane declares failure; legal 1..31.

Ports:
- clkdiv, in, 1, divided word clock; same clock as the PHY's clkdiv_1.
- reset, in, 1, asynchronous active-low reset (0 = reset).
- start, in, 1, single-cycle pulse; begins or restarts training on both lanes.
- din, in, 16, PHY parallel output, format {a[7],b[7],...,a[0],b[0]}, valid bits in the top 2*DATA_WIDTH.
- bitslip_1, out, 1, lane A bitslip pulse to the PHY.
- bitslip_2, out, 1, lane B bitslip pulse to the PHY.
- reva_flag, out, 1, lane A polarity invert to the PHY.
- revb_flag, out, 1, lane B polarity invert to the PHY.
- locked_a, out, 1, lane A aligned.
- locked_b, out, 1, lane B aligned.
- done, out, 1, both lanes in a terminal state (LOCKED or FAIL).
- fail, out, 1, at least one lane in FAIL.
- slip_count_a, out, 5, bitslips issued on lane A since the last start.
- slip_count_b, out, 5, bitslips issued on lane B since the last start.

Behaviour:
Lane word extraction:
- Let O = 16 - 2*DATA_WIDTH.
- wa[i] = din[O+2i+1], wb[i] = din[O+2i], for i = 0..DATA_WIDTH-1.
- PAT = TRAIN_PATTERN[DATA_WIDTH-1:0]; NPAT = ~PAT in the same width.

Reset (asynchronous, reset=0):
- Both lane FSMs go to IDLE.
- All outputs are 0: bitslip, rev flags, locked, done, fail, slip counts.
- Internal settle counter, match counter and the polarity-tried bit are cleared.

Lane FSMs:
- There are two identical, independent FSMs, one per lane.
- All outputs are registered; there is no combinational path from din to any output.
- States: IDLE, SETTLE, CHECK, SLIP, LOCKED, FAIL.

Transitions:
- Any state + start=1: rev=0, slip_count=0, tried=0, locked=0; go to SETTLE with settle counter = SETTLE_CYCLES. start takes priority over every other transition.
- IDLE: hold until start.
- SETTLE: decrement the counter each cycle. When it reaches 0, go to CHECK with match counter = 0. The word seen on the cycle the counter hits 0 is not compared; comparison starts on the first CHECK cycle.
- CHECK, w==PAT: match counter +1. When it reaches MATCH_COUNT, go to LOCKED and set locked=1 on the same edge.
- CHECK, w==NPAT and tried=0: toggle the lane's rev flag, set tried=1, go to SETTLE (reload the counter). This is not counted as a slip.
- CHECK, any other word, or NPAT with tried=1:
  - If slip_count==MAX_SLIPS, go to FAIL.
  - Otherwise go to SLIP.
- SLIP: bitslip is high for exactly this one cycle. slip_count +1, tried=0, go to SETTLE. The rev flag keeps its current value.
- LOCKED: hold all outputs until start or reset; later mismatches are ignored.
- FAIL: hold until start or reset.

Output rules:
- Bitslip is never high for two consecutive cycles.
- Bitslip is never high outside SLIP.
- slip_count saturates by construction: it never exceeds MAX_SLIPS.
- done = (lane A in LOCKED or FAIL) AND (lane B in LOCKED or FAIL), registered.
- fail = either lane in FAIL, registered.

Boundary cases:
- start while a SLIP pulse is due: start wins and no bitslip is issued that cycle.
- Reset mid-training: immediate return to all-zero outputs; the PHY sees rev flags=0 and no bitslip.
- MATCH_COUNT=1: lock on the first matching CHECK word.
- A lane already aligned at start: it locks SETTLE_CYCLES+MATCH_COUNT+1 cycles after start, with zero slips.
- The two lanes progress independently; one lane locking does not stall the other.

Test Plan:
- Both lanes present PAT from start -> locked_a=locked_b=1 and done=1 at cycle 9 after start (defaults); slip counts 0, no bitslip pulses, rev flags 0.
- Lane A misaligned, bench model rotates on each bitslip, 3 slips needed -> exactly 3 single-cycle bitslip_1 pulses, each separated by at least SETTLE_CYCLES+1 cycles; slip_count_a=3, locked_a=1; lane B unaffected.
- Lane B presents NPAT (0x17) -> revb_flag goes to 1 with no bitslip_2; after the model applies the inversion, locked_b=1 and slip_count_b=0.
- Lane A never matches (constant 0x00) -> 16 bitslip_1 pulses, then fail=1, done=1 once lane B is locked, locked_a=0, slip_count_a=16.
- Reset asserted (0) during SETTLE after 2 slips -> all outputs 0 immediately; after release, start re-trains from slip_count 0.
- start pulsed while in LOCKED with rev flags set -> rev flags clear, locked drops next edge, and training repeats to lock.
